// File: rtl/chop.sv
// chop: splits each level-1 transaction into sub-packets of cfg_data beats,
// producing a level-2 stream. Only the in-sub-packet beat counter is stateful.
module chop #(
    parameter int TDIN  = 16,
    parameter int CFG_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [TDIN:0]     din_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CFG_W-1:0]  cfg_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [TDIN+1:0]   dout_data
);

    logic [CFG_W-1:0] cnt_q;
    logic [CFG_W-1:0] cnt_d;
    logic [CFG_W-1:0] last_s;
    logic             din_eot_s;
    logic             inner_eot_s;
    logic             out_hs_s;

    // Index of the final beat in a sub-packet; a size of zero acts as one
    always_comb begin
        if (cfg_data == {CFG_W{1'b0}}) begin
            last_s = {CFG_W{1'b0}};
        end else begin
            last_s = cfg_data - {{(CFG_W-1){1'b0}}, 1'b1};
        end
    end

    // Handshake and zero-latency data path
    always_comb begin
        din_eot_s   = din_data[TDIN];
        inner_eot_s = (cnt_q == last_s) | din_eot_s;
        dout_valid  = din_valid & cfg_valid;
        din_ready   = dout_ready & cfg_valid;
        cfg_ready   = din_valid & din_eot_s & dout_ready;
        out_hs_s    = dout_valid & dout_ready;
        dout_data   = {din_eot_s, inner_eot_s, din_data[TDIN-1:0]};
    end

    // Equality compare plus clear on any eot keeps cnt bounded even if cfg misbehaves
    always_comb begin
        if (out_hs_s) begin
            if (inner_eot_s) begin
                cnt_d = {CFG_W{1'b0}};
            end else begin
                cnt_d = cnt_q + {{(CFG_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Beat counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {CFG_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    chop_chk #(.CFG_W(CFG_W)) u_chk (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .cfg_valid  (cfg_valid),
        .dout_ready (dout_ready),
        .cfg_ready  (cfg_ready),
        .cnt_q      (cnt_q),
        .last_s     (last_s)
    );

endmodule

// Property checker for chop; holds no state of its own.
module chop_chk #(
    parameter int CFG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             cfg_valid,
    input  logic             dout_ready,
    input  logic             cfg_ready,
    input  logic [CFG_W-1:0] cnt_q,
    input  logic [CFG_W-1:0] last_s
);

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst)
        (din_valid && cfg_valid) |-> (cnt_q <= last_s));

    a_cfg_ack_needs_ready: assert property (@(posedge clk) disable iff (!rst)
        cfg_ready |-> dout_ready);

endmodule

// File: tb/tb_chop.sv
// Scoreboard bench for chop: the driver queues hand-computed expected beats,
// a negedge monitor pops and compares on every output handshake.
module tb_chop;
    localparam int TDIN  = 16;
    localparam int CFG_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              din_valid;
    logic              din_ready;
    logic [TDIN:0]     din_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CFG_W-1:0]  cfg_data;
    logic              dout_valid;
    logic              dout_ready;
    logic [TDIN+1:0]   dout_data;

    always #5 clk = ~clk;

    chop #(.TDIN(TDIN), .CFG_W(CFG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data)
    );

    logic [TDIN+1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int ready_ph = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Downstream ready generator: 0 = always ready, 1 = 1,0,0 pattern, 2 = random
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: dout_ready = 1'b1;
            1: begin
                dout_ready = (ready_ph % 3 == 0);
                ready_ph++;
            end
            default: dout_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic [CFG_W-1:0] cnt_prev;
    logic             stall_prev = 1'b0;
    logic [TDIN+1:0]  exp_beat;

    // Monitor: compares on output handshakes, checks gating and stall behaviour
    always @(negedge clk) begin
        if (rst) begin
            if (stall_prev) check("cnt_frozen", 32'(dut.cnt_q), 32'(cnt_prev));
            if (din_valid && !cfg_valid) begin
                check("gate_dout_valid", 32'(dout_valid), 32'd0);
                check("gate_din_ready", 32'(din_ready), 32'd0);
            end
            if (din_valid && cfg_valid && !dout_ready) begin
                check("bp_din_ready", 32'(din_ready), 32'd0);
                check("bp_cfg_ready", 32'(cfg_ready), 32'd0);
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", dout_data);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("dout_data", 32'(dout_data), 32'(exp_beat));
                    check("cfg_hs", 32'(cfg_valid & cfg_ready), 32'(exp_beat[TDIN+1]));
                    check("din_ready", 32'(din_ready), 32'd1);
                end
            end else begin
                check("cfg_no_hs", 32'(cfg_valid & cfg_ready), 32'd0);
            end
            stall_prev = din_valid && cfg_valid && !dout_ready;
            cnt_prev   = dut.cnt_q;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send_beat(input logic [TDIN-1:0] d, input logic eot, input logic inner);
        int n = 0;
        din_data  = {eot, d};
        din_valid = 1'b1;
        exp_q.push_back({eot, inner, d});
        @(negedge clk);
        while (!(din_valid && din_ready)) begin
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL timeout_beat actual=stalled required=handshake data=%0h", d);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 din_valid = 1'b0;
    endtask

    task automatic send_txn(input int base, input int len, input logic [31:0] mask, input logic eot_last);
        for (int i = 0; i < len; i++) begin
            send_beat(16'(base + i), eot_last && (i == len - 1), mask[i]);
        end
    endtask

    initial begin
        int len;
        logic [31:0] mask;
        rst        = 1'b0;
        din_valid  = 1'b0;
        din_data   = '0;
        cfg_valid  = 1'b0;
        cfg_data   = 8'd0;
        dout_ready = 1'b0;
        #7;
        check("reset_cnt", 32'(dut.cnt_q), 32'd0);
        check("reset_dout_valid", 32'(dout_valid), 32'd0);
        #5 rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic chop: size 3, six beats
        cfg_data = 8'd3; cfg_valid = 1'b1;
        send_txn(0, 6, 32'b100100, 1'b1);
        check("cnt_after_basic", 32'(dut.cnt_q), 32'd0);

        // Short tail: size 4, values 10..15
        cfg_data = 8'd4;
        send_txn(10, 6, 32'b101000, 1'b1);
        check("cnt_after_tail", 32'(dut.cnt_q), 32'd0);

        // Size 0 and size 1 give identical streams
        cfg_data = 8'd0;
        send_txn(20, 3, 32'b111, 1'b1);
        cfg_data = 8'd1;
        send_txn(20, 3, 32'b111, 1'b1);
        check("cnt_after_size01", 32'(dut.cnt_q), 32'd0);

        // Backpressure plus cfg held invalid for three cycles
        cfg_valid = 1'b0; cfg_data = 8'd2;
        ready_ph = 0; ready_mode = 1;
        fork
            send_txn(30, 6, 32'b101010, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #2 cfg_valid = 1'b1;
            end
        join
        ready_mode = 0;
        check("cnt_after_bp", 32'(dut.cnt_q), 32'd0);

        // Reset mid-transaction
        cfg_data = 8'd5;
        send_txn(40, 3, 32'b0, 1'b0);
        check("cnt_before_reset", 32'(dut.cnt_q), 32'd3);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("cnt_async_reset", 32'(dut.cnt_q), 32'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        send_txn(50, 5, 32'b10000, 1'b1);
        check("cnt_after_reset_txn", 32'(dut.cnt_q), 32'd0);

        // Random lengths with random ready, size 3
        cfg_data = 8'd3;
        ready_mode = 2;
        for (int t = 0; t < 8; t++) begin
            len  = $urandom_range(1, 20);
            mask = '0;
            for (int i = 0; i < len; i++) begin
                mask[i] = (i % 3 == 2) || (i == len - 1);
            end
            send_txn(100 + t * 32, len, mask, 1'b1);
        end
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("cnt_final", 32'(dut.cnt_q), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
